dpll_lock_ctrl: RTL and testbench

Lock-acquisition sequencer for the DPLL. It enables the DCO, holds then releases the loop filter, and watches the PFD `up`/`down` pulses to declare lock. It detects loss of lock with a windowed error count, re-acquires after a loss, and reports a timeout failure. It sits beside the PFD/LPF in the DPLL top level, is clocked by the PLL-domain clock, and drives the DCO enable, the LPF control and the `locked` indicator.

---
 rtl/dpll_lock_ctrl.sv | 166 ++++++++++++++++
 tb/tb_dpll_lock_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dpll_lock_ctrl.sv
// DPLL lock-acquisition sequencer: settles the DCO, releases the loop filter,
// declares lock from quiet PFD cycles and drops lock on windowed error bursts.
module dpll_lock_ctrl #(
    parameter int LOCK_CYCLES    = 64,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int WINDOW         = 32,
    parameter int UNLOCK_ERRS    = 8,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       up,
    input  logic       down,
    output logic       dco_en,
    output logic       lpf_clear,
    output logic       lpf_hold,
    output logic       locked,
    output logic       fail,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        ACQUIRE = 3'd2,
        LOCKED  = 3'd3,
        FAIL    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LOCK_N   = CNT_W'(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_N = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] TMO_N    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] UNLOCK_N = CNT_W'(UNLOCK_ERRS);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           cur_state, nxt_state;
    logic [CNT_W-1:0] settle_cnt, nxt_settle;
    logic [CNT_W-1:0] quiet, nxt_quiet;
    logic [CNT_W-1:0] tmo, nxt_tmo;
    logic [CNT_W-1:0] win, nxt_win;
    logic [CNT_W-1:0] errs, nxt_errs;
    logic             err_cycle;

    assign err_cycle = up | down;
    assign state     = cur_state;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + ONE;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state  <= IDLE;
            settle_cnt <= '0;
            quiet      <= '0;
            tmo        <= '0;
            win        <= '0;
            errs       <= '0;
        end else begin
            cur_state  <= nxt_state;
            settle_cnt <= nxt_settle;
            quiet      <= nxt_quiet;
            tmo        <= nxt_tmo;
            win        <= nxt_win;
            errs       <= nxt_errs;
        end
    end

    always_comb begin
        nxt_state  = cur_state;
        nxt_settle = settle_cnt;
        nxt_quiet  = quiet;
        nxt_tmo    = tmo;
        nxt_win    = win;
        nxt_errs   = errs;

        if (!start) begin
            nxt_state  = IDLE;
            nxt_settle = '0;
            nxt_quiet  = '0;
            nxt_tmo    = '0;
            nxt_win    = '0;
            nxt_errs   = '0;
        end else begin
            case (cur_state)
                IDLE: begin
                    nxt_state  = SETTLE;
                    nxt_settle = '0;
                    nxt_quiet  = '0;
                    nxt_tmo    = '0;
                    nxt_win    = '0;
                    nxt_errs   = '0;
                end
                SETTLE: begin
                    nxt_settle = sat_inc(settle_cnt);
                    if (nxt_settle >= SETTLE_N) begin
                        nxt_state  = ACQUIRE;
                        nxt_settle = '0;
                        nxt_quiet  = '0;
                        nxt_tmo    = '0;
                    end
                end
                ACQUIRE: begin
                    // Lock is tested before timeout so a tie resolves to LOCKED.
                    nxt_quiet = err_cycle ? '0 : sat_inc(quiet);
                    nxt_tmo   = sat_inc(tmo);
                    if (nxt_quiet == LOCK_N) begin
                        nxt_state = LOCKED;
                        nxt_win   = '0;
                        nxt_errs  = '0;
                    end else if (nxt_tmo >= TMO_N) begin
                        nxt_state = FAIL;
                    end
                end
                LOCKED: begin
                    // The wrap cycle still counts toward the ending window.
                    nxt_errs = err_cycle ? sat_inc(errs) : errs;
                    if (nxt_errs >= UNLOCK_N) begin
                        nxt_state = ACQUIRE;
                        nxt_quiet = '0;
                        nxt_tmo   = '0;
                        nxt_win   = '0;
                        nxt_errs  = '0;
                    end else if (win >= WIN_LAST) begin
                        nxt_win  = '0;
                        nxt_errs = '0;
                    end else begin
                        nxt_win = win + ONE;
                    end
                end
                FAIL: nxt_state = FAIL;
                default: nxt_state = IDLE;
            endcase
        end
    end

    always_comb begin
        dco_en    = 1'b0;
        lpf_clear = 1'b0;
        lpf_hold  = 1'b0;
        locked    = 1'b0;
        fail      = 1'b0;
        case (cur_state)
            IDLE:    lpf_clear = 1'b1;
            SETTLE: begin
                dco_en   = 1'b1;
                lpf_hold = 1'b1;
            end
            ACQUIRE: dco_en = 1'b1;
            LOCKED: begin
                dco_en = 1'b1;
                locked = 1'b1;
            end
            FAIL: begin
                lpf_clear = 1'b1;
                fail      = 1'b1;
            end
            default: lpf_clear = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_dpll_lock_ctrl.sv
// Scoreboard bench for dpll_lock_ctrl: expected output changes and their cycles
// are queued by the stimulus and checked by an independent monitor.
module tb_dpll_lock_ctrl;

    logic       clk;
    logic       rst_n, start, up, down;
    logic       dco_en, lpf_clear, lpf_hold, locked, fail;
    logic [2:0] state;

    logic       start_b;
    logic       dco_en_b, lpf_clear_b, lpf_hold_b, locked_b, fail_b;
    logic [2:0] state_b;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        logic [7:0] vec;
    } exp_t;

    exp_t       sb[$];
    bit         mon_en = 0;
    bit         first  = 1;
    logic [7:0] prev;
    logic [7:0] obs;
    exp_t       ent;

    localparam logic [2:0] S_IDLE = 3'd0, S_SETTLE = 3'd1, S_ACQ = 3'd2,
                           S_LOCKED = 3'd3, S_FAIL = 3'd4;

    dpll_lock_ctrl u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .up        (up),
        .down      (down),
        .dco_en    (dco_en),
        .lpf_clear (lpf_clear),
        .lpf_hold  (lpf_hold),
        .locked    (locked),
        .fail      (fail),
        .state     (state)
    );

    // Lock and timeout thresholds coincide here; lock must win.
    dpll_lock_ctrl #(.LOCK_CYCLES(64), .TIMEOUT_CYCLES(64)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_b),
        .up        (1'b0),
        .down      (1'b0),
        .dco_en    (dco_en_b),
        .lpf_clear (lpf_clear_b),
        .lpf_hold  (lpf_hold_b),
        .locked    (locked_b),
        .fail      (fail_b),
        .state     (state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // {state, dco_en, lpf_clear, lpf_hold, locked, fail}
    function automatic logic [7:0] exp_vec(input logic [2:0] st);
        case (st)
            S_IDLE:   return {S_IDLE,   5'b01000};
            S_SETTLE: return {S_SETTLE, 5'b10100};
            S_ACQ:    return {S_ACQ,    5'b10000};
            S_LOCKED: return {S_LOCKED, 5'b10010};
            S_FAIL:   return {S_FAIL,   5'b01001};
            default:  return 8'h00;
        endcase
    endfunction

    task automatic pushExpect(input int c, input logic [2:0] st);
        exp_t e;
        e.cyc = c;
        e.vec = exp_vec(st);
        sb.push_back(e);
    endtask

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic u, input logic d);
        @(negedge clk);
        start = s;
        up    = u;
        down  = d;
    endtask

    task automatic gotoCycle(input int t);
        while (cyc < t) applyStimulus(start, 1'b0, 1'b0);
    endtask

    always begin
        @(posedge clk);
        #2;
        if (mon_en) begin
            obs = {state, dco_en, lpf_clear, lpf_hold, locked, fail};
            if (first || obs !== prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_change: actual=0x%0h required=0x%0h (no change) at cycle %0d",
                             obs, prev, cyc);
                end else begin
                    ent = sb.pop_front();
                    checkOutput("output_vector", int'(obs), int'(ent.vec));
                    checkOutput("change_cycle", cyc, ent.cyc);
                end
            end
            prev  = obs;
            first = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c, l, l2, l3, f;
        rst_n   = 1'b0;
        start   = 1'b1;
        up      = 1'b0;
        down    = 1'b0;
        start_b = 1'b0;

        // Reset held with start high must still give IDLE outputs.
        repeat (3) @(negedge clk);
        pushExpect(cyc + 1, S_IDLE);
        mon_en = 1;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;

        $display("[TB] clean lock");
        gotoCycle(6);
        c = cyc + 1;
        pushExpect(c + 1,  S_SETTLE);
        pushExpect(c + 17, S_ACQ);
        pushExpect(c + 81, S_LOCKED);
        applyStimulus(1'b1, 1'b0, 1'b0);
        start_b = 1'b1;

        gotoCycle(c + 80);
        checkOutput("b_state_before_lock", int'(state_b), 2);
        checkOutput("b_locked_before_lock", int'(locked_b), 0);
        gotoCycle(c + 81);
        checkOutput("b_state_lock_vs_timeout", int'(state_b), 3);
        checkOutput("b_locked_lock_vs_timeout", int'(locked_b), 1);
        checkOutput("b_fail_lock_vs_timeout", int'(fail_b), 0);
        l = c + 81;

        $display("[TB] 7 errors then 7 errors across a window wrap");
        gotoCycle(l + 24);
        repeat (14) applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);

        $display("[TB] 8 errors in one window with one double pulse");
        gotoCycle(l + 68);
        pushExpect(l + 77,  S_ACQ);
        pushExpect(l + 141, S_LOCKED);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, (i == 3));
        applyStimulus(1'b1, 1'b0, 1'b0);

        gotoCycle(l + 100);
        checkOutput("b_still_locked", int'(state_b), 3);
        checkOutput("b_no_fail", int'(fail_b), 0);
        start_b = 1'b0;
        @(negedge clk);
        checkOutput("b_stop_to_idle", int'(state_b), 0);
        checkOutput("b_stop_dco_off", int'(dco_en_b), 0);

        $display("[TB] 8th error on the wrap cycle");
        l2 = l + 141;
        gotoCycle(l2 + 23);
        pushExpect(l2 + 32, S_ACQ);
        pushExpect(l2 + 96, S_LOCKED);
        repeat (8) applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);

        $display("[TB] start dropped in LOCKED");
        l3 = l2 + 96;
        gotoCycle(l3 + 4);
        pushExpect(l3 + 6, S_IDLE);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] noisy acquire");
        gotoCycle(l3 + 7);
        c = cyc + 1;
        pushExpect(c + 1,   S_SETTLE);
        pushExpect(c + 17,  S_ACQ);
        pushExpect(c + 145, S_LOCKED);
        applyStimulus(1'b1, 1'b0, 1'b0);
        gotoCycle(c + 79);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        gotoCycle(c + 146);

        $display("[TB] timeout");
        f = cyc + 1;
        pushExpect(f + 1, S_IDLE);
        applyStimulus(1'b0, 1'b0, 1'b0);
        c = cyc + 1;
        pushExpect(c + 1,    S_SETTLE);
        pushExpect(c + 17,   S_ACQ);
        pushExpect(c + 4113, S_FAIL);
        while (cyc < c + 4115)
            applyStimulus(1'b1, ((cyc + 1 - c) % 10 == 0), 1'b0);

        f = cyc + 1;
        pushExpect(f + 1, S_IDLE);
        pushExpect(f + 4, S_SETTLE);
        pushExpect(f + 8, S_IDLE);
        applyStimulus(1'b0, 1'b0, 1'b0);
        gotoCycle(f + 2);
        applyStimulus(1'b1, 1'b0, 1'b0);

        $display("[TB] reset during SETTLE with start high");
        gotoCycle(f + 6);
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;

        gotoCycle(f + 15);
        checkOutput("scoreboard_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
